repetition_checker: RTL and testbench

REPETITION_CHECKER -- requirements
Module: repetition_checker

---
 rtl/rep_chk_pkg.sv | 32 +++
 rtl/rep_chk_ch.sv | 132 +++++++++++++
 rtl/repetition_checker.sv | 85 ++++++++
 tb/tb_repetition_checker.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rep_chk_pkg.sv
// Purpose : shared types for the repetition checker (modes, fail causes, FSM states).
// Latency : n/a (types only).
// Backpressure: n/a.
package rep_chk_pkg;

    // Repetition kind applied to busy before the ##1 gnt check.
    typedef enum logic [1:0] {
        REP_CON    = 2'd0,   // busy[*N]
        REP_GOTO   = 2'd1,   // busy[->N]
        REP_NONCON = 2'd2    // busy[=N]
    } rep_mode_e;

    // Cause code reported alongside a fail pulse.
    typedef enum logic [2:0] {
        FC_NONE       = 3'd0,
        FC_BUSY_GAP   = 3'd1,
        FC_NO_GNT     = 3'd2,
        FC_EXTRA_BUSY = 3'd3,
        FC_TIMEOUT    = 3'd4
    } fail_cause_e;

    // Per-channel attempt state.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_GNT_CHK = 2'd2
    } chk_state_e;

    // Repetition counter width; holds BUSY_N up to 15.
    localparam int REP_W = 4;

endpackage

// File: rtl/rep_chk_ch.sv
// Purpose : one channel of the repetition checker; tracks a single req -> busy-repetition -> gnt attempt.
// Latency : pass/fail/overlap are registered, high for one cycle after the deciding sample.
// Backpressure: none; inputs are observed every cycle, a req while active only raises overlap.
// Ports   : clk, rst (sync, active-high), req/busy/gnt in; pass, fail, fail_cause[2:0], overlap out.
module rep_chk_ch
    import rep_chk_pkg::*;
#(
    parameter rep_mode_e MODE    = REP_CON,
    parameter int        BUSY_N  = 3,
    parameter int        TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       busy,
    input  logic       gnt,
    output logic       pass,
    output logic       fail,
    output logic [2:0] fail_cause,
    output logic       overlap
);

    localparam int AGE_W = $clog2(TIMEOUT + 1);

    chk_state_e         state_q,   state_d;
    logic [REP_W-1:0]   rep_q,     rep_d;
    logic [AGE_W-1:0]   age_q,     age_d;
    logic               pass_q,    pass_d;
    logic               fail_q,    fail_d;
    fail_cause_e        cause_q,   cause_d;
    logic               overlap_q, overlap_d;

    logic [REP_W-1:0]   rep_inc;
    logic [AGE_W-1:0]   age_inc;

    assign rep_inc = rep_q + REP_W'(1);
    assign age_inc = age_q + AGE_W'(1);

    always_comb begin
        state_d   = state_q;
        rep_d     = rep_q;
        age_d     = age_q;
        pass_d    = 1'b0;
        fail_d    = 1'b0;
        cause_d   = FC_NONE;
        overlap_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The req cycle only arms the attempt; busy is first sampled next cycle.
                if (req) begin
                    state_d = ST_COUNT;
                    rep_d   = '0;
                    age_d   = '0;
                end
            end
            ST_COUNT: begin
                age_d = age_inc;
                // gnt is deliberately not looked at while counting.
                if (busy) begin
                    rep_d = rep_inc;
                    if (rep_inc == REP_W'(BUSY_N)) begin
                        state_d = ST_GNT_CHK;
                    end
                end else if (MODE == REP_CON) begin
                    fail_d  = 1'b1;
                    cause_d = FC_BUSY_GAP;
                end
            end
            ST_GNT_CHK: begin
                age_d = age_inc;
                if (gnt) begin
                    pass_d = 1'b1;
                end else if (MODE == REP_NONCON) begin
                    // Non-consecutive: idle cycles may precede gnt, another busy may not.
                    if (busy) begin
                        fail_d  = 1'b1;
                        cause_d = FC_EXTRA_BUSY;
                    end
                end else begin
                    fail_d  = 1'b1;
                    cause_d = FC_NO_GNT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_q != ST_IDLE) begin
            // Timeout only fires when nothing else decided this cycle.
            if (!pass_d && !fail_d && age_inc == AGE_W'(TIMEOUT)) begin
                fail_d  = 1'b1;
                cause_d = FC_TIMEOUT;
            end
            if (pass_d || fail_d) begin
                // A req in the deciding cycle starts a fresh attempt back-to-back.
                state_d = req ? ST_COUNT : ST_IDLE;
                rep_d   = '0;
                age_d   = '0;
            end else if (req) begin
                overlap_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rep_q     <= '0;
            age_q     <= '0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            cause_q   <= FC_NONE;
            overlap_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rep_q     <= rep_d;
            age_q     <= age_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            cause_q   <= cause_d;
            overlap_q <= overlap_d;
        end
    end

    assign pass       = pass_q;
    assign fail       = fail_q;
    assign fail_cause = cause_q;
    assign overlap    = overlap_q;

endmodule

// File: rtl/repetition_checker.sv
// Purpose : NUM_CH independent req/busy/gnt repetition checkers plus saturating pass/fail totals.
// Latency : per-channel pulses one cycle after the deciding sample; totals one cycle after the pulses.
// Backpressure: none; monitor only, never stalls its inputs.
// Ports   : clk, rst (sync, active-high), req/busy/gnt[NUM_CH]; pass/fail/overlap[NUM_CH],
//           fail_cause[3*NUM_CH] (3 bits per channel), pass_cnt/fail_cnt[CNT_W].
module repetition_checker
    import rep_chk_pkg::*;
#(
    parameter int        NUM_CH  = 4,
    parameter int        BUSY_N  = 3,
    parameter rep_mode_e MODE    = REP_CON,
    parameter int        TIMEOUT = 64,
    parameter int        CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     req,
    input  logic [NUM_CH-1:0]     busy,
    input  logic [NUM_CH-1:0]     gnt,
    output logic [NUM_CH-1:0]     pass,
    output logic [NUM_CH-1:0]     fail,
    output logic [3*NUM_CH-1:0]   fail_cause,
    output logic [NUM_CH-1:0]     overlap,
    output logic [CNT_W-1:0]      pass_cnt,
    output logic [CNT_W-1:0]      fail_cnt
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        rep_chk_ch #(
            .MODE    (MODE),
            .BUSY_N  (BUSY_N),
            .TIMEOUT (TIMEOUT)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .req        (req[g]),
            .busy       (busy[g]),
            .gnt        (gnt[g]),
            .pass       (pass[g]),
            .fail       (fail[g]),
            .fail_cause (fail_cause[3*g +: 3]),
            .overlap    (overlap[g])
        );
    end

    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [CNT_W:0]   pass_pop, fail_pop;

    // Adds b to a, clamping at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W:0]   b);
        logic [CNT_W+1:0] s;
        s = {2'b00, a} + {1'b0, b};
        if (s > {2'b00, {CNT_W{1'b1}}}) begin
            return {CNT_W{1'b1}};
        end
        return s[CNT_W-1:0];
    endfunction

    always_comb begin
        pass_pop = '0;
        fail_pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pass_pop = pass_pop + {{CNT_W{1'b0}}, pass[i]};
            fail_pop = fail_pop + {{CNT_W{1'b0}}, fail[i]};
        end
        pass_cnt_d = sat_add(pass_cnt_q, pass_pop);
        fail_cnt_d = sat_add(fail_cnt_q, fail_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_repetition_checker.sv
// Purpose : directed self-checking bench for repetition_checker, one instance per repetition mode.
// Latency : outputs sampled 1ns after each rising edge.
// Backpressure: n/a.
module tb_repetition_checker;
    import rep_chk_pkg::*;

    localparam int NCH = 4;
    localparam int CW  = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] req, busy, gnt;

    logic [NCH-1:0]   c_pass, c_fail, c_ovl, g_pass, g_fail, g_ovl, n_pass, n_fail, n_ovl;
    logic [3*NCH-1:0] c_cause, g_cause, n_cause;
    logic [CW-1:0]    c_pcnt, c_fcnt, g_pcnt, g_fcnt, n_pcnt, n_fcnt;

    always #5 clk = ~clk;

    repetition_checker #(.NUM_CH(NCH), .BUSY_N(3), .MODE(REP_CON), .TIMEOUT(64), .CNT_W(CW)) u_con (
        .clk(clk), .rst(rst), .req(req), .busy(busy), .gnt(gnt),
        .pass(c_pass), .fail(c_fail), .fail_cause(c_cause), .overlap(c_ovl),
        .pass_cnt(c_pcnt), .fail_cnt(c_fcnt));

    repetition_checker #(.NUM_CH(NCH), .BUSY_N(3), .MODE(REP_GOTO), .TIMEOUT(64), .CNT_W(CW)) u_goto (
        .clk(clk), .rst(rst), .req(req), .busy(busy), .gnt(gnt),
        .pass(g_pass), .fail(g_fail), .fail_cause(g_cause), .overlap(g_ovl),
        .pass_cnt(g_pcnt), .fail_cnt(g_fcnt));

    repetition_checker #(.NUM_CH(NCH), .BUSY_N(3), .MODE(REP_NONCON), .TIMEOUT(64), .CNT_W(CW)) u_non (
        .clk(clk), .rst(rst), .req(req), .busy(busy), .gnt(gnt),
        .pass(n_pass), .fail(n_fail), .fail_cause(n_cause), .overlap(n_ovl),
        .pass_cnt(n_pcnt), .fail_cnt(n_fcnt));

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one input vector and return just after the edge that samples it.
    task automatic drive(input logic [NCH-1:0] r, input logic [NCH-1:0] b, input logic [NCH-1:0] g);
        req  = r;
        busy = b;
        gnt  = g;
        tick();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        busy = '0;
        gnt  = '0;
        tick();
        tick();
        rst  = 1'b0;
    endtask

    // req, then busy on ch0 in the 1,0,1,0,1 pattern.
    task automatic req_alt_busy();
        drive(4'h1, 4'h0, 4'h0);
        drive(4'h0, 4'h1, 4'h0);
        drive(4'h0, 4'h0, 4'h0);
        drive(4'h0, 4'h1, 4'h0);
        drive(4'h0, 4'h0, 4'h0);
        drive(4'h0, 4'h1, 4'h0);
    endtask

    logic [NCH-1:0] sticky;

    initial begin
        rst  = 1'b1;
        req  = '0;
        busy = '0;
        gnt  = '0;

        // Reset state
        do_reset();
        check("rst_pass",  c_pass,  0);
        check("rst_fail",  c_fail,  0);
        check("rst_cause", c_cause, 0);
        check("rst_ovl",   c_ovl,   0);
        check("rst_pcnt",  c_pcnt,  0);
        check("rst_fcnt",  c_fcnt,  0);

        // Consecutive: busy x3 then gnt passes
        do_reset();
        drive(4'h1, 4'h0, 4'h0);
        drive(4'h0, 4'h1, 4'h0);
        drive(4'h0, 4'h1, 4'h0);
        drive(4'h0, 4'h1, 4'h0);
        check("con_pass_early", c_pass, 0);
        drive(4'h0, 4'h0, 4'h1);
        check("con_pass", c_pass, 4'h1);
        check("con_pass_nofail", c_fail, 0);
        drive(4'h0, 4'h0, 4'h0);
        check("con_pass_oneshot", c_pass, 0);
        check("con_pass_cnt", c_pcnt, 1);
        check("con_pass_fcnt", c_fcnt, 0);

        // req in the deciding cycle starts a new attempt without overlap
        do_reset();
        drive(4'h1, 4'h0, 4'h0);
        drive(4'h0, 4'h1, 4'h0);
        drive(4'h0, 4'h1, 4'h0);
        drive(4'h0, 4'h1, 4'h0);
        drive(4'h1, 4'h0, 4'h1);
        check("b2b_pass1", c_pass, 4'h1);
        check("b2b_no_ovl", c_ovl, 0);
        drive(4'h0, 4'h1, 4'h0);
        drive(4'h0, 4'h1, 4'h0);
        drive(4'h0, 4'h1, 4'h0);
        drive(4'h0, 4'h0, 4'h1);
        check("b2b_pass2", c_pass, 4'h1);
        drive(4'h0, 4'h0, 4'h0);
        check("b2b_pcnt", c_pcnt, 2);

        // Consecutive: busy gap fails two cycles after req
        do_reset();
        drive(4'h1, 4'h0, 4'h0);
        drive(4'h0, 4'h1, 4'h0);
        check("gap_fail_early", c_fail, 0);
        drive(4'h0, 4'h0, 4'h0);
        check("gap_fail", c_fail, 4'h1);
        check("gap_cause", c_cause[2:0], 3'd1);
        drive(4'h0, 4'h0, 4'h0);
        check("gap_fail_oneshot", c_fail, 0);
        check("gap_cause_clear", c_cause, 0);
        check("gap_fcnt", c_fcnt, 1);

        // Goto: gnt right after third busy passes
        do_reset();
        req_alt_busy();
        check("goto_pass_early", g_pass, 0);
        drive(4'h0, 4'h0, 4'h1);
        check("goto_pass", g_pass, 4'h1);
        check("goto_nofail", g_fail, 0);

        // Goto: gnt one cycle late fails NO_GNT
        do_reset();
        req_alt_busy();
        drive(4'h0, 4'h0, 4'h0);
        check("goto_late_fail", g_fail, 4'h1);
        check("goto_late_cause", g_cause[2:0], 3'd2);

        // Non-consecutive: five idle cycles then gnt passes
        do_reset();
        req_alt_busy();
        for (int i = 0; i < 5; i++) drive(4'h0, 4'h0, 4'h0);
        check("non_wait_pass", n_pass, 0);
        check("non_wait_fail", n_fail, 0);
        drive(4'h0, 4'h0, 4'h1);
        check("non_pass", n_pass, 4'h1);

        // Non-consecutive: fourth busy fails EXTRA_BUSY
        do_reset();
        req_alt_busy();
        drive(4'h0, 4'h0, 4'h0);
        check("non_extra_early", n_fail, 0);
        drive(4'h0, 4'h1, 4'h0);
        check("non_extra_fail", n_fail, 4'h1);
        check("non_extra_cause", n_cause[2:0], 3'd3);

        // Goto: no busy -> timeout 64 cycles after req; mid-attempt req -> overlap
        do_reset();
        drive(4'h1, 4'h0, 4'h0);
        for (int i = 1; i < 10; i++) drive(4'h0, 4'h0, 4'h0);
        drive(4'h1, 4'h0, 4'h0);
        check("ovl_pulse", g_ovl, 4'h1);
        drive(4'h0, 4'h0, 4'h0);
        check("ovl_oneshot", g_ovl, 0);
        for (int i = 12; i < 64; i++) drive(4'h0, 4'h0, 4'h0);
        check("tmo_early", g_fail, 0);
        drive(4'h0, 4'h0, 4'h0);
        check("tmo_fail", g_fail, 4'h1);
        check("tmo_cause", g_cause[2:0], 3'd4);

        // Reset mid-attempt abandons it; req during reset is ignored
        do_reset();
        drive(4'h1, 4'h0, 4'h0);
        drive(4'h0, 4'h1, 4'h0);
        drive(4'h0, 4'h1, 4'h0);
        rst = 1'b1;
        drive(4'h1, 4'h1, 4'h0);
        rst = 1'b0;
        check("rst_mid_pass", c_pass, 0);
        check("rst_mid_fail", c_fail, 0);
        sticky = '0;
        drive(4'h0, 4'h0, 4'h1);
        sticky = sticky | c_pass | c_fail;
        for (int i = 0; i < 70; i++) begin
            drive(4'h0, 4'h0, 4'h0);
            sticky = sticky | c_pass | c_fail;
        end
        check("rst_mid_quiet", sticky, 0);
        check("rst_mid_pcnt", c_pcnt, 0);
        check("rst_mid_fcnt", c_fcnt, 0);

        // All four channels pass together -> pass_cnt +4
        do_reset();
        drive(4'hF, 4'h0, 4'h0);
        drive(4'h0, 4'hF, 4'h0);
        drive(4'h0, 4'hF, 4'h0);
        drive(4'h0, 4'hF, 4'h0);
        drive(4'h0, 4'h0, 4'hF);
        check("all_pass", c_pass, 4'hF);
        drive(4'h0, 4'h0, 4'h0);
        check("all_pcnt", c_pcnt, 4);
        check("all_fcnt", c_fcnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
